// File: rtl/skinny_sbox8_inv_hpc2_1_ctrl.sv
// -----------------------------------------------------------------------------
// skinny_sbox8_inv_hpc2_1_ctrl
//
// Masked (two-share, first-order) SKINNY-128 inverse 8-bit S-box.
//
// The inverse S-box is computed as
//   SWAP, MIX, PINV, MIX, PINV, MIX, PINV, MIX
// where SWAP exchanges bits 1 and 2, PINV is the inverse of the forward bit
// permutation, and MIX is the involution
//   x0 ^= NOR(x3, x2);  x4 ^= NOR(x7, x6).
// SWAP and PINV are linear, so they are applied to each share separately.
// Each MIX uses two HPC2 (x NOR y) XOR z gadgets, so the datapath has eight
// gadgets. Gadget k consumes randomness bit r[k] only. Each MIX layer takes
// two cycles, so the latency from the accepting edge to done is 8 cycles.
//
// Ports
//   clk    : clock, rising edge active
//   rst    : asynchronous active-high reset
//   start  : compute request, sampled only while idle (also in the done cycle)
//   si1/si0: input shares (value = si1 ^ si0)
//   r      : 8 bits of fresh randomness, bit k feeds gadget k
//   busy   : high while an operation is in flight
//   done   : one-cycle pulse, bo1/bo0 valid
//   bo1/bo0: output shares (bo1 ^ bo0 = S8_inv(si1 ^ si0))
//
// Configuration
//   SBOX_INV_ZEROIZE_EN : when defined, bo1/bo0 read 8'h00 in every cycle
//   except the done cycle, and the working/gadget registers are cleared on
//   the return to IDLE. When undefined, bo1/bo0 hold the last result.
// -----------------------------------------------------------------------------
module skinny_sbox8_inv_hpc2_1_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] si1,
    input  logic [7:0] si0,
    input  logic [7:0] r,
    output logic       busy,
    output logic       done,
    output logic [7:0] bo1,
    output logic [7:0] bo0
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] bo1_q, bo1_d;
    logic [7:0] bo0_q, bo0_d;

    // Working shares: loaded with the inputs on accept, then overwritten with
    // the output of each MIX layer.
    logic [7:0] s1_q, s1_d;
    logic [7:0] s0_q, s0_d;
    logic [7:0] r_q, r_d;

    // First-stage HPC2 registers, one bit per gadget:
    //   g_r    : Reg[r_k]
    //   g_b1r  : Reg[b1 ^ r_k], cross-domain term used by share 0
    //   g_b0r  : Reg[b0 ^ r_k], cross-domain term used by share 1
    logic [7:0] g_r_q,   g_r_d;
    logic [7:0] g_b1r_q, g_b1r_d;
    logic [7:0] g_b0r_q, g_b0r_d;

    // Combinational layer signals
    logic [1:0] layer;
    logic [2:0] ga, gb;
    logic [7:0] lin1, lin0;
    logic [7:0] mix1, mix0;
    logic       a1_a, a0_a, b1_a, b0_a;
    logic       a1_b, a0_b, b1_b, b0_b;
    logic       c1_a, c0_a, c1_b, c0_b;

    // Exchange bits 1 and 2 (its own inverse).
    function automatic logic [7:0] swap8(input logic [7:0] x);
        return {x[7:3], x[1], x[2], x[0]};
    endfunction

    // Inverse of the forward SKINNY S8 bit permutation.
    function automatic logic [7:0] pinv8(input logic [7:0] x);
        return {x[5], x[4], x[0], x[3], x[1], x[7], x[6], x[2]};
    endfunction

    // Second stage of an order-1 HPC2 AND for output share i:
    //   c_i = a_i b_i ^ (~a_i & Reg[r]) ^ (a_i & Reg[b_j ^ r])
    // The operand a_i and b_i come straight from the working registers,
    // which stay stable across both cycles of a layer.
    function automatic logic hpc2_out(input logic a, input logic b,
                                      input logic rr, input logic bxr);
        return (a & b) ^ (~a & rr) ^ (a & bxr);
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        s1_d    = s1_q;
        s0_d    = s0_q;
        r_d     = r_q;
        g_r_d   = g_r_q;
        g_b1r_d = g_b1r_q;
        g_b0r_d = g_b0r_q;
`ifdef SBOX_INV_ZEROIZE_EN
        bo1_d   = 8'h00;
        bo0_d   = 8'h00;
`else
        bo1_d   = bo1_q;
        bo0_d   = bo0_q;
`endif

        // Two cycles per layer; gadgets 2L and 2L+1 belong to layer L.
        layer = cnt_q[2:1];
        ga    = {layer, 1'b0};
        gb    = {layer, 1'b1};

        // Linear step in front of the MIX, share by share.
        lin1 = (layer == 2'd0) ? swap8(s1_q) : pinv8(s1_q);
        lin0 = (layer == 2'd0) ? swap8(s0_q) : pinv8(s0_q);

        // NOR(x, y) = (~x) & (~y); a shared value is negated by inverting
        // share 0 only, so the two shares never meet.
        a1_a = lin1[3];
        a0_a = ~lin0[3];
        b1_a = lin1[2];
        b0_a = ~lin0[2];
        a1_b = lin1[7];
        a0_b = ~lin0[7];
        b1_b = lin1[6];
        b0_b = ~lin0[6];

        c1_a = hpc2_out(a1_a, b1_a, g_r_q[ga], g_b0r_q[ga]);
        c0_a = hpc2_out(a0_a, b0_a, g_r_q[ga], g_b1r_q[ga]);
        c1_b = hpc2_out(a1_b, b1_b, g_r_q[gb], g_b0r_q[gb]);
        c0_b = hpc2_out(a0_b, b0_b, g_r_q[gb], g_b1r_q[gb]);

        // The XOR with z is linear and stays within each share.
        mix1    = lin1;
        mix1[0] = lin1[0] ^ c1_a;
        mix1[4] = lin1[4] ^ c1_b;
        mix0    = lin0;
        mix0[0] = lin0[0] ^ c0_a;
        mix0[4] = lin0[4] ^ c0_b;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                    s1_d    = si1;
                    s0_d    = si0;
                    r_d     = r;
                end
            end

            RUN: begin
                cnt_d = cnt_q + 3'd1;
                if (!cnt_q[0]) begin
                    // First gadget stage: refresh the cross-domain operand.
                    g_r_d[ga]   = r_q[ga];
                    g_b1r_d[ga] = b1_a ^ r_q[ga];
                    g_b0r_d[ga] = b0_a ^ r_q[ga];
                    g_r_d[gb]   = r_q[gb];
                    g_b1r_d[gb] = b1_b ^ r_q[gb];
                    g_b0r_d[gb] = b0_b ^ r_q[gb];
                end else begin
                    // Second gadget stage: commit the layer result.
                    s1_d = mix1;
                    s0_d = mix0;
                end

                if (cnt_q == 3'd7) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bo1_d   = mix1;
                    bo0_d   = mix0;
`ifdef SBOX_INV_ZEROIZE_EN
                    s1_d    = 8'h00;
                    s0_d    = 8'h00;
                    r_d     = 8'h00;
                    g_r_d   = 8'h00;
                    g_b1r_d = 8'h00;
                    g_b0r_d = 8'h00;
`endif
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its _d signal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bo1_q   <= 8'h00;
            bo0_q   <= 8'h00;
            s1_q    <= 8'h00;
            s0_q    <= 8'h00;
            r_q     <= 8'h00;
            g_r_q   <= 8'h00;
            g_b1r_q <= 8'h00;
            g_b0r_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bo1_q   <= bo1_d;
            bo0_q   <= bo0_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
            r_q     <= r_d;
            g_r_q   <= g_r_d;
            g_b1r_q <= g_b1r_d;
            g_b0r_q <= g_b0r_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bo1  = bo1_q;
    assign bo0  = bo0_q;

endmodule

// File: tb/tb_skinny_sbox8_inv_hpc2_1_ctrl.sv
// -----------------------------------------------------------------------------
// tb_skinny_sbox8_inv_hpc2_1_ctrl
//
// Directed bench for the masked SKINNY-128 inverse S-box. Known S8 table
// points give hand-computed expectations; the full sweep maps each result
// back through an independent forward S8 model.
// -----------------------------------------------------------------------------
module tb_skinny_sbox8_inv_hpc2_1_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] si1;
    logic [7:0] si0;
    logic [7:0] r;
    logic       busy;
    logic       done;
    logic [7:0] bo1;
    logic [7:0] bo0;

    int n_cmp = 0;
    int n_err = 0;

    skinny_sbox8_inv_hpc2_1_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .si1  (si1),
        .si0  (si0),
        .r    (r),
        .busy (busy),
        .done (done),
        .bo1  (bo1),
        .bo0  (bo0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Forward SKINNY S8 model.
    function automatic logic [7:0] f_mix(input logic [7:0] x);
        logic [7:0] y;
        y    = x;
        y[0] = x[0] ^ ~(x[3] | x[2]);
        y[4] = x[4] ^ ~(x[7] | x[6]);
        return y;
    endfunction

    function automatic logic [7:0] f_perm(input logic [7:0] x);
        return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5)
             | ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    endfunction

    function automatic logic [7:0] f_swap(input logic [7:0] x);
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    function automatic logic [7:0] s8(input logic [7:0] x);
        logic [7:0] y;
        y = f_mix(x);
        y = f_mix(f_perm(y));
        y = f_mix(f_perm(y));
        y = f_mix(f_perm(y));
        return f_swap(y);
    endfunction

    // Call #1 after a posedge or at a negedge with the DUT idle (or in its
    // done cycle). Returns #1 after the edge raising done.
    task automatic run_op(input logic [7:0] x, input logic [7:0] m, input logic [7:0] rv,
                          output logic [7:0] res, output int lat,
                          output logic busy_acc, output logic busy_done);
        si1   = x ^ m;
        si0   = m;
        r     = rv;
        start = 1'b1;
        @(posedge clk);
        #1;
        busy_acc = busy;
        start    = 1'b0;
        // Inputs are free to change once accepted.
        si1 = 8'($urandom);
        si0 = 8'($urandom);
        r   = 8'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 20);
        res       = bo1 ^ bo0;
        busy_done = busy;
    endtask

    initial begin
        logic [7:0] res;
        logic [7:0] res0;
        logic [7:0] res1;
        logic       b_acc;
        logic       b_done;
        int         lat;
        int         n_done;
        int         t0;
        int         t1;
        int         wait_n;

        rst   = 1'b1;
        start = 1'b0;
        si1   = 8'h00;
        si0   = 8'h00;
        r     = 8'h00;
        res0  = 8'h00;
        res1  = 8'h00;
        t0    = -1;
        t1    = -1;

        // Reset state, before any clock edge.
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bo1",  {24'd0, bo1},  32'd0);
        check("rst_bo0",  {24'd0, bo0},  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // S8(00) = 65, shares unmasked, no randomness.
        run_op(8'h65, 8'h00, 8'h00, res, lat, b_acc, b_done);
        check("inv65_res",       {24'd0, res}, 32'h00);
        check("inv65_lat",       lat,          8);
        check("inv65_busy_acc",  {31'd0, b_acc},  32'd1);
        check("inv65_busy_done", {31'd0, b_done}, 32'd0);

        // S8(01) = 4C, random split, r = A5.
        run_op(8'h4C, 8'h9E, 8'hA5, res, lat, b_acc, b_done);
        check("inv4C_res", {24'd0, res}, 32'h01);
        check("inv4C_lat", lat,          8);

        // S8(FF) = FF.
        run_op(8'hFF, 8'h37, 8'h5C, res, lat, b_acc, b_done);
        check("invFF_res", {24'd0, res}, 32'hFF);

        // S8(02) = 6A.
        run_op(8'h6A, 8'hD1, 8'hFF, res, lat, b_acc, b_done);
        check("inv6A_res", {24'd0, res}, 32'h02);

        // Output between operations.
        @(posedge clk);
        #1;
`ifdef SBOX_INV_ZEROIZE_EN
        check("zero_bo1_a", {24'd0, bo1}, 32'h00);
        check("zero_bo0_a", {24'd0, bo0}, 32'h00);
`else
        check("hold_res_a", {24'd0, bo1 ^ bo0}, 32'h02);
`endif
        repeat (3) @(posedge clk);
        #1;
`ifdef SBOX_INV_ZEROIZE_EN
        check("zero_bo1_b", {24'd0, bo1}, 32'h00);
        check("zero_bo0_b", {24'd0, bo0}, 32'h00);
`else
        check("hold_res_b", {24'd0, bo1 ^ bo0}, 32'h02);
`endif

        // Full sweep, back-to-back, checked through the forward S8.
        for (int x = 0; x < 256; x++) begin
            for (int j = 0; j < 4; j++) begin
                run_op(8'(x), 8'($urandom), 8'($urandom), res, lat, b_acc, b_done);
                check($sformatf("sweep_%02h_%0d", x, j), {24'd0, s8(res)}, x);
                check($sformatf("sweep_lat_%02h_%0d", x, j), lat, 8);
            end
        end

        // start held high for 20 cycles, inputs changed at cycle 3.
        @(negedge clk);
        si1    = 8'h65 ^ 8'h3C;
        si0    = 8'h3C;
        r      = 8'h5A;
        start  = 1'b1;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 3) begin
                si1 = 8'hFF ^ 8'hC3;
                si0 = 8'hC3;
                r   = 8'h99;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (n_done == 0) begin
                    res0 = bo1 ^ bo0;
                    t0   = c;
                end else if (n_done == 1) begin
                    res1 = bo1 ^ bo0;
                    t1   = c;
                end
                n_done++;
            end
        end
        start = 1'b0;
        check("hold_n_done", n_done, 2);
        check("hold_t0",     t0,     8);
        check("hold_t1",     t1,     17);
        check("hold_res0",   {24'd0, res0}, 32'h00);
        check("hold_res1",   {24'd0, res1}, 32'hFF);
        // Drain the third operation accepted while start was still high.
        wait_n = 0;
        while (!done && wait_n < 12) begin
            @(negedge clk);
            wait_n++;
        end
        check("hold_drain", {31'd0, done}, 32'd1);
        @(negedge clk);

        // Reset in the middle of a run.
        si1   = 8'h4C ^ 8'h55;
        si0   = 8'h55;
        r     = 8'h0F;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_bo1",  {24'd0, bo1},  32'h00);
        check("mid_rst_bo0",  {24'd0, bo0},  32'h00);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("mid_rst_quiet", n_done, 0);
        run_op(8'h4C, 8'hE7, 8'h3B, res, lat, b_acc, b_done);
        check("post_rst_res", {24'd0, res}, 32'h01);
        check("post_rst_lat", lat,          8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
